route_lock_ctrl: RTL and testbench

ROUTE_LOCK_CTRL -- requirements
Module: route_lock_ctrl

---
 rtl/route_lock_ctrl.sv | 106 ++++++++++
 tb/tb_route_lock_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/route_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : route_lock_ctrl
// Brief    : Per-route interlocking lock/release controller with round-robin
//            grant arbitration and timed release.
// Revision : 1.0
// ============================================================================
module route_lock_ctrl #(
    parameter int          NUM_ROUTES     = 8,
    parameter int          RELEASE_CYCLES = 8,
    parameter logic [63:0] CONFLICT       = 64'h41A0_5028_140A_0582
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NUM_ROUTES-1:0] i_Req,
    input  logic                  i_Emerg,
    output logic [NUM_ROUTES-1:0] o_Lock,
    output logic [NUM_ROUTES-1:0] o_Release,
    output logic [NUM_ROUTES-1:0] o_Pending
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_LOCKED    = 2'd1;
    localparam logic [1:0] c_ST_RELEASING = 2'd2;

    localparam logic [7:0] c_REL_LOAD = 8'(RELEASE_CYCLES - 1);

    logic [1:0]            r_state [NUM_ROUTES];
    logic [7:0]            r_cnt   [NUM_ROUTES];
    logic [2:0]            r_ptr;

    logic [NUM_ROUTES-1:0] w_blocking;
    logic [NUM_ROUTES-1:0] w_eligible;
    logic                  w_grant_valid;
    logic [2:0]            w_grant_idx;
    logic [NUM_ROUTES-1:0] w_grant;

    // A route still in RELEASING keeps blocking until it has actually reached IDLE.
    generate
        for (genvar r = 0; r < NUM_ROUTES; r++) begin : g_route
            logic [NUM_ROUTES-1:0] w_conf_row;
            assign w_blocking[r] = (r_state[r] != c_ST_IDLE);
            assign w_conf_row    = CONFLICT[r*8 +: NUM_ROUTES] & ~(NUM_ROUTES'(1) << r);
            assign w_eligible[r] = (r_state[r] == c_ST_IDLE) && i_Req[r] && !i_Emerg &&
                                   ((w_conf_row & w_blocking) == '0);
        end
    endgenerate

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 3'd0;
        for (int k = 0; k < NUM_ROUTES; k++) begin
            if (!w_grant_valid && w_eligible[r_ptr + 3'(k)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = r_ptr + 3'(k);
            end
        end
        w_grant = w_grant_valid ? (NUM_ROUTES'(1) << w_grant_idx) : '0;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int r = 0; r < NUM_ROUTES; r++) begin
                r_state[r] <= c_ST_IDLE;
                r_cnt[r]   <= 8'd0;
            end
            r_ptr     <= 3'd0;
            o_Lock    <= '0;
            o_Release <= '0;
            o_Pending <= '0;
        end else begin
            for (int r = 0; r < NUM_ROUTES; r++) begin
                case (r_state[r])
                    c_ST_IDLE: begin
                        if (w_grant[r]) begin
                            r_state[r] <= c_ST_LOCKED;
                        end
                    end
                    c_ST_LOCKED: begin
                        if (!i_Req[r] || i_Emerg) begin
                            r_state[r] <= c_ST_RELEASING;
                            r_cnt[r]   <= c_REL_LOAD;
                        end
                    end
                    c_ST_RELEASING: begin
                        if (r_cnt[r] == 8'd0) begin
                            r_state[r] <= c_ST_IDLE;
                        end else begin
                            r_cnt[r] <= r_cnt[r] - 8'd1;
                        end
                    end
                    default: r_state[r] <= c_ST_IDLE;
                endcase
                // Status flags are decoded from the pre-edge state so they stay one-hot per route.
                o_Lock[r]    <= (r_state[r] == c_ST_LOCKED);
                o_Release[r] <= (r_state[r] == c_ST_RELEASING);
                o_Pending[r] <= (r_state[r] == c_ST_IDLE) && i_Req[r];
            end
            if (w_grant_valid) begin
                r_ptr <= w_grant_idx + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_route_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_route_lock_ctrl
// Brief    : Scoreboard bench for route_lock_ctrl with directed vectors and a
//            randomised safety-invariant run.
// Revision : 1.0
// ============================================================================
module tb_route_lock_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [7:0] i_Req = 8'h00;
    logic       i_Emerg = 1'b0;
    logic [7:0] o_Lock;
    logic [7:0] o_Release;
    logic [7:0] o_Pending;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q  [$];
    string       name_q [$];

    route_lock_ctrl #(
        .NUM_ROUTES     (8),
        .RELEASE_CYCLES (8),
        .CONFLICT       (64'h41A0_5028_140A_0582)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Req     (i_Req),
        .i_Emerg   (i_Emerg),
        .o_Lock    (o_Lock),
        .o_Release (o_Release),
        .o_Pending (o_Pending)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic bit ring_conf(input int a, input int b);
        return (((a + 1) % 8) == b) || (((b + 1) % 8) == a);
    endfunction

    // Drive one cycle of stimulus and queue what the outputs must show after the next edge.
    task automatic step(input logic rst, input logic [7:0] req, input logic em,
                        input logic [7:0] el, input logic [7:0] er, input logic [7:0] ep,
                        input string nm);
        @(negedge i_Clk);
        i_Rst   = rst;
        i_Req   = req;
        i_Emerg = em;
        exp_q.push_back({el, er, ep});
        name_q.push_back(nm);
    endtask

    logic [23:0] m_exp;
    string       m_name;
    logic [7:0]  m_blk;
    bit          m_viol;

    always @(posedge i_Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            checks++;
            if ({o_Lock, o_Release, o_Pending} !== m_exp) begin
                errors++;
                $display("FAIL %s: got lock=%h rel=%h pend=%h, expected lock=%h rel=%h pend=%h",
                         m_name, o_Lock, o_Release, o_Pending,
                         m_exp[23:16], m_exp[15:8], m_exp[7:0]);
            end
        end
        m_blk  = o_Lock | o_Release;
        m_viol = ((o_Lock & o_Release) | (o_Lock & o_Pending) | (o_Release & o_Pending)) != 8'h00;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (i != j && ring_conf(i, j) && m_blk[i] && m_blk[j]) m_viol = 1'b1;
            end
        end
        checks++;
        if (m_viol || $isunknown({o_Lock, o_Release, o_Pending})) begin
            errors++;
            $display("FAIL invariant at %0t: lock=%h rel=%h pend=%h, required conflict-free one-hot",
                     $time, o_Lock, o_Release, o_Pending);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and single request
        step(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, "reset");
        step(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, "reset_hold");
        step(0, 8'h10, 0, 8'h00, 8'h00, 8'h10, "single_pend");
        step(0, 8'h10, 0, 8'h10, 8'h00, 8'h00, "single_lock");

        // D waits on locked E, then on E's timed release
        step(0, 8'h18, 0, 8'h10, 8'h00, 8'h08, "conf_pend");
        step(0, 8'h18, 0, 8'h10, 8'h00, 8'h08, "conf_hold");
        step(0, 8'h08, 0, 8'h10, 8'h00, 8'h08, "conf_drop");
        for (int k = 0; k < 8; k++) step(0, 8'h08, 0, 8'h00, 8'h10, 8'h08, "conf_releasing");
        step(0, 8'h08, 0, 8'h00, 8'h00, 8'h08, "conf_e_idle");
        step(0, 8'h08, 0, 8'h08, 8'h00, 8'h00, "conf_d_lock");

        // Reset while D's release counter is at 3
        step(0, 8'h00, 0, 8'h08, 8'h00, 8'h00, "rmr_drop");
        for (int k = 0; k < 4; k++) step(0, 8'h00, 0, 8'h00, 8'h08, 8'h00, "rmr_rel");
        step(1, 8'h08, 0, 8'h00, 8'h00, 8'h00, "rmr_reset");
        step(0, 8'h08, 0, 8'h00, 8'h00, 8'h08, "rmr_first_grant");
        step(0, 8'h08, 0, 8'h08, 8'h00, 8'h00, "rmr_relock");

        // Round-robin: A then E; later B beats A from pointer 1
        step(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, "rr_reset");
        step(0, 8'h11, 0, 8'h00, 8'h00, 8'h11, "rr_pend");
        step(0, 8'h11, 0, 8'h01, 8'h00, 8'h10, "rr_a_lock");
        step(0, 8'h11, 0, 8'h11, 8'h00, 8'h00, "rr_e_lock");
        step(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, "rr_reset2");
        step(0, 8'h01, 0, 8'h00, 8'h00, 8'h01, "rr2_a_pend");
        step(0, 8'h00, 0, 8'h01, 8'h00, 8'h00, "rr2_a_lock");
        for (int k = 0; k < 8; k++) step(0, 8'h00, 0, 8'h00, 8'h01, 8'h00, "rr2_a_rel");
        step(0, 8'h03, 0, 8'h00, 8'h00, 8'h03, "rr2_b_grant");
        step(0, 8'h03, 0, 8'h02, 8'h00, 8'h01, "rr2_b_lock");
        step(0, 8'h03, 0, 8'h02, 8'h00, 8'h01, "rr2_a_blocked");

        // Emergency: blocks grants, then releases A,C,E,G together
        step(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, "em_reset");
        step(0, 8'h01, 1, 8'h00, 8'h00, 8'h01, "em_block");
        step(0, 8'h01, 1, 8'h00, 8'h00, 8'h01, "em_block_hold");
        step(0, 8'h55, 0, 8'h00, 8'h00, 8'h55, "em_g1");
        step(0, 8'h55, 0, 8'h01, 8'h00, 8'h54, "em_g2");
        step(0, 8'h55, 0, 8'h05, 8'h00, 8'h50, "em_g3");
        step(0, 8'h55, 0, 8'h15, 8'h00, 8'h40, "em_g4");
        step(0, 8'h55, 0, 8'h55, 8'h00, 8'h00, "em_all_locked");
        step(0, 8'h55, 1, 8'h55, 8'h00, 8'h00, "em_pulse");
        for (int k = 0; k < 8; k++) step(0, 8'h55, 0, 8'h00, 8'h55, 8'h00, "em_rel");
        step(0, 8'h55, 0, 8'h00, 8'h00, 8'h55, "em_idle");
        step(0, 8'h55, 0, 8'h01, 8'h00, 8'h54, "em_relock1");
        step(0, 8'h55, 0, 8'h05, 8'h00, 8'h50, "em_relock2");
        step(0, 8'h55, 0, 8'h15, 8'h00, 8'h40, "em_relock3");
        step(0, 8'h55, 0, 8'h55, 8'h00, 8'h00, "em_relock4");

        // Random stress; the monitor's per-cycle invariant check covers it
        for (int k = 0; k < 10000; k++) begin
            @(negedge i_Clk);
            i_Req   = 8'($urandom);
            i_Emerg = ($urandom_range(0, 15) == 0);
            i_Rst   = ($urandom_range(0, 499) == 0);
        end

        step(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, "final_reset");
        repeat (2) @(posedge i_Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
